// File: rtl/scalar_mult_ctrl.sv
// Constant-time left-to-right double-and-add-always sequencer for a projective
// twisted-Edwards point adder; produces Q = k*P over a start/finished handshake.
module scalar_mult_ctrl #(
  parameter int unsigned  NBITS = 255,
  parameter logic [254:0] ID_X  = 255'd0,
  parameter logic [254:0] ID_YZ = 255'd1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_scalar,
  input  logic [254:0]     i_px,
  input  logic [254:0]     i_py,
  input  logic [254:0]     i_pz,
  output logic             o_busy,
  output logic [254:0]     o_x,
  output logic [254:0]     o_y,
  output logic [254:0]     o_z,
  output logic             o_valid,
  output logic             o_pa_start,
  output logic             o_pa_doubling,
  output logic [254:0]     o_pa_x1,
  output logic [254:0]     o_pa_y1,
  output logic [254:0]     o_pa_z1,
  output logic [254:0]     o_pa_x2,
  output logic [254:0]     o_pa_y2,
  output logic [254:0]     o_pa_z2,
  input  logic [254:0]     i_pa_x3,
  input  logic [254:0]     i_pa_y3,
  input  logic [254:0]     i_pa_z3,
  input  logic             i_pa_finished
);

  localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {IDLE, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [254:0]     r_x, r_y, r_z, r_x_nx, r_y_nx, r_z_nx;
  logic [254:0]     p_x, p_y, p_z;
  logic [NBITS-1:0] s, s_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             load;

  always_comb begin
    state_nx = state;
    r_x_nx   = r_x;
    r_y_nx   = r_y;
    r_z_nx   = r_z;
    s_nx     = s;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load     = 1'b1;
          s_nx     = i_scalar;
          r_x_nx   = ID_X;
          r_y_nx   = ID_YZ;
          r_z_nx   = ID_YZ;
          cnt_nx   = CW'(NBITS - 1);
          state_nx = DBL_REQ;
        end
      end
      DBL_REQ: state_nx = DBL_WAIT;
      DBL_WAIT: begin
        if (i_pa_finished) begin
          r_x_nx   = i_pa_x3;
          r_y_nx   = i_pa_y3;
          r_z_nx   = i_pa_z3;
          state_nx = ADD_REQ;
        end
      end
      ADD_REQ: state_nx = ADD_WAIT;
      ADD_WAIT: begin
        if (i_pa_finished) begin
          // the add always runs; only the commit depends on the scalar bit
          if (s[NBITS-1]) begin
            r_x_nx = i_pa_x3;
            r_y_nx = i_pa_y3;
            r_z_nx = i_pa_z3;
          end
          s_nx = s << 1;
          if (cnt == '0) begin
            state_nx = DONE;
          end else begin
            cnt_nx   = cnt - CW'(1);
            state_nx = DBL_REQ;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the
  // very cycle its state is occupied, without a combinational path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
      p_x           <= '0;
      p_y           <= '0;
      p_z           <= '0;
      s             <= '0;
      cnt           <= '0;
      o_busy        <= 1'b0;
      o_valid       <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_z           <= '0;
      o_pa_start    <= 1'b0;
      o_pa_doubling <= 1'b0;
      o_pa_x1       <= '0;
      o_pa_y1       <= '0;
      o_pa_z1       <= '0;
      o_pa_x2       <= '0;
      o_pa_y2       <= '0;
      o_pa_z2       <= '0;
    end else begin
      state <= state_nx;
      r_x   <= r_x_nx;
      r_y   <= r_y_nx;
      r_z   <= r_z_nx;
      s     <= s_nx;
      cnt   <= cnt_nx;
      if (load) begin
        p_x <= i_px;
        p_y <= i_py;
        p_z <= i_pz;
      end
      o_busy     <= (state_nx != IDLE);
      o_valid    <= (state_nx == DONE);
      o_pa_start <= (state_nx == DBL_REQ) || (state_nx == ADD_REQ);
      if (state_nx == DBL_REQ) begin
        o_pa_doubling <= 1'b1;
        o_pa_x1       <= r_x_nx;
        o_pa_y1       <= r_y_nx;
        o_pa_z1       <= r_z_nx;
        o_pa_x2       <= r_x_nx;
        o_pa_y2       <= r_y_nx;
        o_pa_z2       <= r_z_nx;
      end
      if (state_nx == ADD_REQ) begin
        o_pa_doubling <= 1'b0;
        o_pa_x1       <= r_x_nx;
        o_pa_y1       <= r_y_nx;
        o_pa_z1       <= r_z_nx;
        o_pa_x2       <= p_x;
        o_pa_y2       <= p_y;
        o_pa_z2       <= p_z;
      end
      if (state_nx == DONE) begin
        o_x <= r_x_nx;
        o_y <= r_y_nx;
        o_z <= r_z_nx;
      end
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl with NBITS=8 and a fixed-latency (L=5) adder stand-in:
// group law (x1+x2, y1*y2, z1*z2) mod PM, neutral (0,1,1), so k*B = (k*bx, by^k, bz^k).
module tb_scalar_mult_ctrl;

  localparam longint PM  = 64'd1000003;
  localparam int     L   = 5;
  localparam int     LAT = 2 * 8 * (1 + L) + 1;

  logic         clk = 1'b0;
  logic         i_rst, i_start, i_pa_finished;
  logic [7:0]   i_scalar;
  logic [254:0] i_px, i_py, i_pz, i_pa_x3, i_pa_y3, i_pa_z3;
  logic         o_busy, o_valid, o_pa_start, o_pa_doubling;
  logic [254:0] o_x, o_y, o_z;
  logic [254:0] o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scalar_mult_ctrl #(.NBITS(8), .ID_X(255'd0), .ID_YZ(255'd1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_scalar(i_scalar),
    .i_px(i_px), .i_py(i_py), .i_pz(i_pz),
    .o_busy(o_busy), .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_valid(o_valid),
    .o_pa_start(o_pa_start), .o_pa_doubling(o_pa_doubling),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1),
    .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2),
    .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3),
    .i_pa_finished(i_pa_finished)
  );

  // adder stand-in and request monitor
  int     pulses = 0, pat_bad = 0, copy_bad = 0, cd = 0;
  bit     exp_dbl = 1'b1, a_dbl;
  longint ax1, ay1, az1, ax2, ay2, az2;

  initial begin
    i_pa_finished = 1'b0;
    i_pa_x3 = '0;
    i_pa_y3 = '0;
    i_pa_z3 = '0;
  end

  always @(negedge clk) begin
    i_pa_finished = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_pa_finished = 1'b1;
        if (a_dbl) begin
          i_pa_x3 = 255'((2 * ax1) % PM);
          i_pa_y3 = 255'((ay1 * ay1) % PM);
          i_pa_z3 = 255'((az1 * az1) % PM);
        end else begin
          i_pa_x3 = 255'((ax1 + ax2) % PM);
          i_pa_y3 = 255'((ay1 * ay2) % PM);
          i_pa_z3 = 255'((az1 * az2) % PM);
        end
      end
    end
    if (o_pa_start) begin
      pulses++;
      if (o_pa_doubling !== exp_dbl) pat_bad++;
      if (o_pa_doubling && ({o_pa_x2, o_pa_y2, o_pa_z2} !== {o_pa_x1, o_pa_y1, o_pa_z1}))
        copy_bad++;
      exp_dbl = ~exp_dbl;
      a_dbl = o_pa_doubling;
      ax1 = longint'(o_pa_x1[31:0]);
      ay1 = longint'(o_pa_y1[31:0]);
      az1 = longint'(o_pa_z1[31:0]);
      ax2 = longint'(o_pa_x2[31:0]);
      ay2 = longint'(o_pa_y2[31:0]);
      az2 = longint'(o_pa_z2[31:0]);
      cd = L;
    end
    if (!o_busy) exp_dbl = 1'b1;
  end

  function automatic longint powm(input longint b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % PM;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int k);
    chk({tag, "_x"}, o_x, 255'((longint'(k) * 7) % PM));
    chk({tag, "_y"}, o_y, 255'(powm(3, k)));
    chk({tag, "_z"}, o_z, 255'(powm(5, k)));
  endtask

  task automatic start_op(input logic [7:0] k, input bit hold);
    @(negedge clk);
    i_scalar = k;
    i_start  = 1'b1;
    @(negedge clk);
    if (!hold) i_start = 1'b0;
  endtask

  // returns the number of edges from the accepting edge up to the o_valid edge
  task automatic wait_valid(input int poke_at, input logic [7:0] poke_k, output int lat);
    lat = 1;
    while (!o_valid && lat < 400) begin
      if (poke_at != 0 && lat == poke_at) begin
        i_start  = 1'b1;
        i_scalar = poke_k;
      end
      if (poke_at != 0 && lat == poke_at + 1) i_start = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [7:0] k, input int poke_at,
                           input logic [7:0] poke_k);
    int lat, p0;
    p0 = pulses;
    start_op(k, 1'b0);
    chk({tag, "_busy"}, 255'(o_busy), 255'd1);
    wait_valid(poke_at, poke_k, lat);
    chk({tag, "_lat"}, 255'(lat), 255'(LAT));
    chk_q(tag, int'(k));
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 255'(o_valid), 255'd0);
    chk({tag, "_idle"}, 255'(o_busy), 255'd0);
    chk_q({tag, "_held"}, int'(k));
    chk({tag, "_pulses"}, 255'(pulses - p0), 255'd16);
    chk({tag, "_pattern"}, 255'(pat_bad), 255'd0);
    chk({tag, "_dbl_copy"}, 255'(copy_bad), 255'd0);
  endtask

  initial begin
    int lat, p0, gap, hold_bad, zero_bad;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_scalar = '0;
    i_px     = 255'd7;
    i_py     = 255'd3;
    i_pz     = 255'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy", 255'(o_busy), 255'd0);
    chk("rst_valid", 255'(o_valid), 255'd0);
    chk("rst_x", o_x, 255'd0);
    chk("rst_y", o_y, 255'd0);
    chk("rst_z", o_z, 255'd0);
    chk("rst_pa_start", 255'(o_pa_start), 255'd0);
    chk("rst_pa_dbl", 255'(o_pa_doubling), 255'd0);
    chk("rst_pa_ops", 255'(|{o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2}), 255'd0);
    i_rst = 1'b0;

    run_check("k00", 8'h00, 0, 8'h00);
    run_check("k01", 8'h01, 0, 8'h00);
    run_check("kff", 8'hff, 0, 8'h00);
    run_check("k80", 8'h80, 0, 8'h00);
    run_check("k5a_poke", 8'h5a, 40, 8'hc3);

    // reset lands in DBL_WAIT; the in-flight finished pulse arrives 2 cycles later
    p0 = pulses;
    start_op(8'h11, 1'b0);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    zero_bad = 0;
    repeat (10) begin
      if (o_busy || o_valid || o_pa_start || o_pa_doubling ||
          (|{o_x, o_y, o_z, o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2}))
        zero_bad++;
      @(negedge clk);
    end
    chk("abort_outputs_zero", 255'(zero_bad), 255'd0);
    chk("abort_pulses", 255'(pulses - p0), 255'd1);
    run_check("k03_after_rst", 8'h03, 0, 8'h00);

    // back-to-back with i_start held high
    p0 = pulses;
    start_op(8'h05, 1'b1);
    i_scalar = 8'h02;
    wait_valid(0, 8'h00, lat);
    chk("b2b_first_lat", 255'(lat), 255'(LAT));
    chk_q("b2b_first", 5);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!o_pa_start && gap < 10);
    chk("b2b_restart_gap", 255'(gap), 255'd2);
    lat = 1;
    hold_bad = 0;
    while (!o_valid && lat < 400) begin
      if ({o_x, o_y, o_z} !== {255'd35, 255'd243, 255'd3125}) hold_bad++;
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    chk("b2b_second_lat", 255'(lat), 255'(LAT));
    chk("b2b_hold", 255'(hold_bad), 255'd0);
    chk_q("b2b_second", 2);
    chk("b2b_pulses", 255'(pulses - p0), 255'd32);
    repeat (3) @(negedge clk);
    chk("b2b_end_idle", 255'(o_busy), 255'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Upstream sequencer for the twisted-Edwards point adder/doubler.
- Computes Q = k·P in projective coordinates using constant-time left-to-right double-and-add-always.
- Issues one doubling request and one addition request per scalar bit over a start/finished handshake, and captures each result.
- Delivers the final (X,Y,Z) to the projective-to-affine stage.

Parameters:
- NBITS, 255, number of scalar bits processed (MSB first); every scalar costs exactly NBITS iterations.
- ID_X, 255'd0, X coordinate of the neutral point, in the representation the point adder consumes.
- ID_YZ, 255'd1, Y and Z coordinate of the neutral point, same representation.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  request; sampled only in IDLE
- i_scalar  in  NBITS  scalar k; latched on accepted i_start
- i_px, i_py, i_pz  in  255 each  base point P; latched on accepted i_start
- o_busy  out  1  high in every state except IDLE
- o_x, o_y, o_z  out  255 each  result Q; valid while o_valid is high, held until the next accepted start
- o_valid  out  1  one-cycle pulse when the result is ready
- o_pa_start  out  1  one-cycle request pulse to the point adder
- o_pa_doubling  out  1  request type: 1 = double (x1,y1,z1), 0 = add point 1 + point 2
- o_pa_x1, o_pa_y1, o_pa_z1  out  255 each  operand point 1 (always R)
- o_pa_x2, o_pa_y2, o_pa_z2  out  255 each  operand point 2 (P on add; copy of R on double)
- i_pa_x3, i_pa_y3, i_pa_z3  in  255 each  adder result; valid in the cycle i_pa_finished is high
- i_pa_finished  in  1  one-cycle completion pulse from the adder

Behaviour:
- Reset values:
  - state IDLE; all outputs 0, except o_y = o_z = 0 as well.
  - Internal R = 0, P = 0, scalar shift register = 0, bit counter = 0.
- Reset has priority in every state. It aborts any operation and issues no further o_pa_start. A late i_pa_finished after reset is ignored (the state is IDLE).
- All outputs are registered, with no combinational input-to-output path.
- IDLE:
  - On i_start: latch the scalar into shift register S and P into the P registers.
  - Set R = (ID_X, ID_YZ, ID_YZ), counter = NBITS-1.
  - Go to DBL_REQ.
- DBL_REQ:
  - Drive o_pa_start=1, o_pa_doubling=1, operand 1 = R, operand 2 = R for exactly one cycle.
  - Go to DBL_WAIT.
- DBL_WAIT:
  - Operand outputs are held stable; o_pa_start=0.
  - On i_pa_finished: R <= result; go to ADD_REQ.
- ADD_REQ:
  - Drive o_pa_start=1, o_pa_doubling=0, operand 1 = R, operand 2 = P for one cycle.
  - Go to ADD_WAIT.
- ADD_WAIT: on i_pa_finished:
  - If S[NBITS-1] is 1: R <= result. Otherwise R is unchanged and the result is discarded. The add is always performed, which gives constant time.
  - S shifts left by 1, zero fill.
  - If counter == 0, go to DONE; otherwise decrement the counter and go to DBL_REQ.
- DONE:
  - o_x/o_y/o_z <= R, o_valid=1 for one cycle, o_busy stays high this cycle.
  - Next state is IDLE.
- i_start while busy is ignored; there is no queuing.
- i_start in the same cycle as o_valid is also ignored, because the state is still DONE.
- i_pa_finished in REQ or IDLE states is ignored. This is a protocol error, not recovered.
- Op cost:
  - If the adder raises finished L cycles after seeing o_pa_start, each op costs 1 + L cycles.
  - Total latency from the cycle after the accepted i_start to the o_valid cycle is NBITS·2·(1+L) + 1 cycles, independent of k.
- Exactly 2·NBITS o_pa_start pulses per operation, alternating doubling=1 then 0.
- The bit counter is ceil(log2(NBITS)) bits wide. Use an explicit ==0 compare, with no wrap-around.

Test Plan:
- Setup for all scenarios: NBITS=8, fixed-latency adder model L=5 with an exact modular reference model.
- k=0, P=base point B -> o_valid after 2·8·6+1 = 97 cycles; Q = (ID_X, ID_YZ, ID_YZ) projectively; 16 o_pa_start pulses, doubling pattern 1,0 repeated.
- k=1 -> Q projectively equals B (X·Zref == Xref·Z, Y likewise); latency 97 cycles.
- k=8'hFF and k=8'h80 -> Q equals 255·B and 128·B respectively. Latency is identical to k=0, which confirms constant time.
- i_start pulsed at cycle 40 of a running op with a different scalar -> ignored; result and latency are those of the first request; no extra o_pa_start.
- i_rst asserted during DBL_WAIT, and a stray i_pa_finished arrives 2 cycles later -> all outputs 0, o_busy=0, no o_pa_start. A following i_start with k=3 produces 3·B correctly.
- Back-to-back: i_start held high continuously -> second operation begins the cycle after DONE→IDLE. o_x/o_y/o_z hold the first result until o_valid of the second.
